stopwatch_ctrl: RTL and testbench

Central run/mode sequencer for the stopwatch. It sits between the debounce outputs and the timekeeping datapath, and turns debounced button levels into clean one-cycle commands. It owns the IDLE/RUN/PAUSE/DONE state machine, auto-repeat for the minute and hour set buttons, countdown-expiry detection, and the alarm blink. The datapath counts only while run_en is high and follows the clr, min_inc, hour_inc and count_down commands.

---
 rtl/stopwatch_ctrl_pkg.sv | 18 +
 rtl/stopwatch_ctrl_if.sv | 30 +++
 rtl/stopwatch_ctrl_btn_repeat.sv | 44 ++++
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: state encoding and
// default tick-derived timing constants.
package stopwatch_pkg;

  typedef logic [1:0] sw_state_t;

  localparam sw_state_t S_IDLE  = 2'd0;
  localparam sw_state_t S_RUN   = 2'd1;
  localparam sw_state_t S_PAUSE = 2'd2;
  localparam sw_state_t S_DONE  = 2'd3;

  localparam int unsigned TICK_HZ          = 100;
  localparam int unsigned BLINK_TICKS      = TICK_HZ / 4;
  localparam int unsigned ALARM_TICKS      = 3 * TICK_HZ;
  localparam int unsigned REPEAT_DELAY_DEF = TICK_HZ / 2;
  localparam int unsigned REPEAT_RATE_DEF  = TICK_HZ / 10;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/flag inputs and datapath command outputs of the stopwatch sequencer.
interface stopwatch_ctrl_if;

  logic       tick;
  logic       btn_clr;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_min;
  logic       btn_hour;
  logic       sw_cd;
  logic       time_zero;
  logic       run_en;
  logic       clr;
  logic       min_inc;
  logic       hour_inc;
  logic       count_down;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output tick, btn_clr, btn_start, btn_stop, btn_min, btn_hour, sw_cd, time_zero,
    input  run_en, clr, min_inc, hour_inc, count_down, alarm, state
  );

  modport slave (
    input  tick, btn_clr, btn_start, btn_stop, btn_min, btn_hour, sw_cd, time_zero,
    output run_en, clr, min_inc, hour_inc, count_down, alarm, state
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_repeat.sv
// Set-button channel: one pulse on a sampled rising edge, then auto-repeat
// while held, counting ticks.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY = stopwatch_pkg::REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = stopwatch_pkg::REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  input  logic i_lvl_d,
  input  logic i_tick,
  input  logic i_en,
  output logic o_pulse
);

  localparam int unsigned CW = $clog2(REPEAT_DELAY + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_rise;
  logic          w_rep;
  logic          r_pulse;

  assign w_rise    = i_lvl & ~i_lvl_d;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_rep     = i_tick && (w_cnt_inc == CW'(REPEAT_DELAY));

  // After each repeat the counter rewinds by REPEAT_RATE so it never exceeds REPEAT_DELAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      if (!i_en || !i_lvl)
        r_cnt <= '0;
      else if (i_tick)
        r_cnt <= w_rep ? CW'(REPEAT_DELAY - REPEAT_RATE) : w_cnt_inc;
      r_pulse <= i_en && i_lvl && (w_rise || w_rep);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/mode sequencer: button edges to one-cycle datapath commands,
// IDLE/RUN/PAUSE/DONE control, countdown expiry and alarm blink.
module stopwatch_ctrl #(
  parameter int unsigned REPEAT_DELAY = stopwatch_pkg::REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = stopwatch_pkg::REPEAT_RATE_DEF,
  parameter int unsigned ALARM_TICKS  = stopwatch_pkg::ALARM_TICKS,
  parameter int unsigned BLINK_TICKS  = stopwatch_pkg::BLINK_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  import stopwatch_pkg::*;

  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);

  logic          r_clr_s, r_clr_p, r_start_s, r_start_p, r_stop_s, r_stop_p;
  logic          r_min_s, r_min_p, r_hour_s, r_hour_p;
  logic          r_tick, r_sw_cd, r_tz;
  sw_state_t     r_state, w_state_nxt;
  logic          r_run_en, r_clr, r_cd, w_cd_nxt, r_alarm, w_alarm_nxt;
  logic [AW-1:0] r_acnt, w_acnt_nxt, w_acnt_inc;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_inc;
  logic          w_clr_rise, w_start_rise, w_stop_rise, w_set_en;
  logic          w_min_pulse, w_hour_pulse;

  assign w_clr_rise   = r_clr_s   & ~r_clr_p;
  assign w_start_rise = r_start_s & ~r_start_p;
  assign w_stop_rise  = r_stop_s  & ~r_stop_p;
  assign w_acnt_inc   = r_acnt + AW'(1);
  assign w_bcnt_inc   = r_bcnt + BW'(1);
  assign w_set_en     = ((r_state == S_IDLE) || (r_state == S_PAUSE)) && !w_clr_rise;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_hour (
    .clk(clk), .rst_n(rst_n), .i_lvl(r_hour_s), .i_lvl_d(r_hour_p),
    .i_tick(r_tick), .i_en(w_set_en), .o_pulse(w_hour_pulse)
  );

  // A held hour button starves the minute channel, including its counter.
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_min (
    .clk(clk), .rst_n(rst_n), .i_lvl(r_min_s), .i_lvl_d(r_min_p),
    .i_tick(r_tick), .i_en(w_set_en && !r_hour_s), .o_pulse(w_min_pulse)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_alarm_nxt = r_alarm;
    w_acnt_nxt  = r_acnt;
    w_bcnt_nxt  = r_bcnt;
    if (w_clr_rise) begin
      w_state_nxt = S_IDLE;
      w_alarm_nxt = 1'b0;
      w_acnt_nxt  = '0;
      w_bcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_rise && !w_stop_rise && !(r_sw_cd && r_tz)) begin
            w_state_nxt = S_RUN;
            w_cd_nxt    = r_sw_cd;
          end
        end
        S_RUN: begin
          if (w_stop_rise) begin
            w_state_nxt = S_PAUSE;
          end else if (r_cd && r_tz) begin
            w_state_nxt = S_DONE;
            w_alarm_nxt = 1'b1;
            w_acnt_nxt  = '0;
            w_bcnt_nxt  = '0;
          end
        end
        S_PAUSE: begin
          if (w_start_rise && !w_stop_rise)
            w_state_nxt = S_RUN;
        end
        default: begin
          if (w_start_rise || w_stop_rise || (r_tick && (w_acnt_inc == AW'(ALARM_TICKS)))) begin
            w_state_nxt = S_IDLE;
            w_alarm_nxt = 1'b0;
            w_acnt_nxt  = '0;
            w_bcnt_nxt  = '0;
          end else if (r_tick) begin
            w_acnt_nxt = w_acnt_inc;
            if (w_bcnt_inc == BW'(BLINK_TICKS)) begin
              w_alarm_nxt = ~r_alarm;
              w_bcnt_nxt  = '0;
            end else begin
              w_bcnt_nxt = w_bcnt_inc;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_clr_s, r_clr_p, r_start_s, r_start_p, r_stop_s, r_stop_p} <= '0;
      {r_min_s, r_min_p, r_hour_s, r_hour_p}                       <= '0;
      {r_tick, r_sw_cd, r_tz}                                      <= '0;
      r_state  <= S_IDLE;
      r_run_en <= 1'b0;
      r_clr    <= 1'b0;
      r_cd     <= 1'b0;
      r_alarm  <= 1'b0;
      r_acnt   <= '0;
      r_bcnt   <= '0;
    end else begin
      r_clr_s   <= bus.btn_clr;   r_clr_p   <= r_clr_s;
      r_start_s <= bus.btn_start; r_start_p <= r_start_s;
      r_stop_s  <= bus.btn_stop;  r_stop_p  <= r_stop_s;
      r_min_s   <= bus.btn_min;   r_min_p   <= r_min_s;
      r_hour_s  <= bus.btn_hour;  r_hour_p  <= r_hour_s;
      r_tick    <= bus.tick;
      r_sw_cd   <= bus.sw_cd;
      r_tz      <= bus.time_zero;
      r_state   <= w_state_nxt;
      r_run_en  <= (w_state_nxt == S_RUN);
      r_clr     <= w_clr_rise;
      r_cd      <= w_cd_nxt;
      r_alarm   <= w_alarm_nxt;
      r_acnt    <= w_acnt_nxt;
      r_bcnt    <= w_bcnt_nxt;
    end
  end

  assign bus.state      = r_state;
  assign bus.run_en     = r_run_en;
  assign bus.clr        = r_clr;
  assign bus.min_inc    = w_min_pulse;
  assign bus.hour_inc   = w_hour_pulse;
  assign bus.count_down = r_cd;
  assign bus.alarm      = r_alarm;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// button traffic, compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  import stopwatch_pkg::*;

  localparam int RD = 50;
  localparam int RR = 10;
  localparam int AT = 300;
  localparam int BT = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, b_clr = 1'b0, b_start = 1'b0, b_stop = 1'b0;
  logic b_min = 1'b0, b_hour = 1'b0, sw_cd = 1'b0, tz = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_clr = 0, cnt_min = 0, cnt_hour = 0;

  stopwatch_ctrl_if bus ();

  assign bus.tick      = tick;
  assign bus.btn_clr   = b_clr;
  assign bus.btn_start = b_start;
  assign bus.btn_stop  = b_stop;
  assign bus.btn_min   = b_min;
  assign bus.btn_hour  = b_hour;
  assign bus.sw_cd     = sw_cd;
  assign bus.time_zero = tz;

  stopwatch_ctrl #(
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ALARM_TICKS(AT), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: input samples at the last two edges, mode, latched direction,
  // ticks spent in DONE and ticks each set button has been held.
  typedef struct packed {
    logic clr, start, stop, mn, hr, cd, tz, tk;
  } smp_t;

  smp_t s_cur, s_prev;
  int   m_st, m_t, m_hn, m_mn;
  bit   m_cd, e_clr, e_min, e_hour;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic al;
    al = (m_st == int'(S_DONE)) && ((m_t / BT) % 2 == 0);
    return {2'(m_st), m_st == int'(S_RUN), e_clr, e_min, e_hour, m_cd, al};
  endfunction

  function automatic logic [7:0] act_vec();
    return {bus.state, bus.run_en, bus.clr, bus.min_inc, bus.hour_inc, bus.count_down, bus.alarm};
  endfunction

  task automatic model_reset();
    m_st = int'(S_IDLE); m_cd = 0; m_t = 0; m_hn = 0; m_mn = 0;
    e_clr = 0; e_min = 0; e_hour = 0;
    s_cur = '0; s_prev = '0;
  endtask

  task automatic chan_step(input bit en, input bit lvl, input bit plvl, input bit tk,
                           input int n_in, output int n_out, output bit p);
    p = 0;
    n_out = n_in;
    if (!en || !lvl) begin
      n_out = 0;
    end else begin
      if (!plvl) p = 1;
      if (tk) begin
        n_out = n_in + 1;
        if (n_out == RD || (n_out > RD && (n_out - RD) % RR == 0)) p = 1;
      end
    end
  endtask

  task automatic model_step();
    smp_t s_new;
    bit clr_r, start_r, stop_r, setm;
    s_new.clr = b_clr;  s_new.start = b_start; s_new.stop = b_stop;
    s_new.mn  = b_min;  s_new.hr    = b_hour;  s_new.cd   = sw_cd;
    s_new.tz  = tz;     s_new.tk    = tick;
    clr_r   = s_cur.clr   && !s_prev.clr;
    start_r = s_cur.start && !s_prev.start;
    stop_r  = s_cur.stop  && !s_prev.stop;
    setm = (m_st == int'(S_IDLE) || m_st == int'(S_PAUSE)) && !clr_r;
    chan_step(setm, s_cur.hr, s_prev.hr, s_cur.tk, m_hn, m_hn, e_hour);
    chan_step(setm && !s_cur.hr, s_cur.mn, s_prev.mn, s_cur.tk, m_mn, m_mn, e_min);
    e_clr = clr_r;
    if (clr_r) begin
      m_st = int'(S_IDLE);
    end else begin
      case (2'(m_st))
        S_IDLE:  if (start_r && !stop_r && !(s_cur.cd && s_cur.tz)) begin
                   m_st = int'(S_RUN); m_cd = s_cur.cd;
                 end
        S_RUN:   if (stop_r) m_st = int'(S_PAUSE);
                 else if (m_cd && s_cur.tz) begin m_st = int'(S_DONE); m_t = 0; end
        S_PAUSE: if (start_r && !stop_r) m_st = int'(S_RUN);
        default: if (start_r || stop_r) m_st = int'(S_IDLE);
                 else if (s_cur.tk) begin
                   m_t++;
                   if (m_t == AT) m_st = int'(S_IDLE);
                 end
      endcase
    end
    s_prev = s_cur;
    s_cur  = s_new;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("outs", act_vec(), exp_vec());
    cnt_clr  += int'(bus.clr);
    cnt_min  += int'(bus.min_inc);
    cnt_hour += int'(bus.hour_inc);
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; cycle();
      tick = 1'b0; cycle(); cycle();
    end
  endtask

  task automatic press_start();
    b_start = 1'b1; cycles(2);
    b_start = 1'b0; cycles(2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", act_vec(), 8'h00);
    model_reset();
    rst_n = 1'b1;
    cycles(3);

    // start / stop / resume
    press_start();
    chk("start_run", bus.state, S_RUN);
    chk("start_run_en", bus.run_en, 1);
    ticks(3);
    b_stop = 1'b1; cycles(2); b_stop = 1'b0; cycles(2);
    chk("stop_pause", bus.state, S_PAUSE);
    chk("stop_run_en", bus.run_en, 0);
    sw_cd = 1'b1;
    press_start();
    chk("resume_run", bus.state, S_RUN);
    chk("resume_cd_kept", bus.count_down, 0);
    b_start = 1'b1; b_stop = 1'b1; cycles(2); b_start = 1'b0; b_stop = 1'b0; cycles(2);
    chk("both_in_run", bus.state, S_PAUSE);
    cnt_clr = 0;
    b_clr = 1'b1; cycles(4); b_clr = 1'b0; cycles(2);
    chk("clr_idle", bus.state, S_IDLE);
    chk("clr_once", cnt_clr, 1);
    b_start = 1'b1; b_stop = 1'b1; cycles(2); b_start = 1'b0; b_stop = 1'b0; cycles(2);
    chk("both_in_idle", bus.state, S_IDLE);
    sw_cd = 1'b0;

    // minute hold auto-repeat
    cnt_min = 0;
    b_min = 1'b1; cycle();
    ticks(120);
    b_min = 1'b0;
    ticks(20);
    chk("min_hold_pulses", cnt_min, 9);

    // hour priority over minute
    cnt_min = 0; cnt_hour = 0;
    b_hour = 1'b1; b_min = 1'b1; cycle();
    ticks(60);
    chk("hour_prio_hour", cnt_hour, 3);
    chk("hour_prio_min", cnt_min, 0);
    b_hour = 1'b0; cycles(2);
    ticks(50);
    chk("min_after_hour", cnt_min, 1);
    b_min = 1'b0; cycles(3);

    // set buttons ignored in RUN
    press_start();
    cnt_min = 0;
    b_min = 1'b1; cycle(); ticks(55); b_min = 1'b0; cycles(2);
    chk("min_ignored_run", cnt_min, 0);
    b_clr = 1'b1; cycles(2); b_clr = 1'b0; cycles(2);

    // countdown expiry, alarm and acknowledge
    sw_cd = 1'b1; tz = 1'b1;
    press_start();
    chk("cd_zero_idle", bus.state, S_IDLE);
    chk("cd_zero_run_en", bus.run_en, 0);
    tz = 1'b0;
    press_start();
    chk("cd_run", bus.state, S_RUN);
    chk("cd_latched", bus.count_down, 1);
    ticks(5);
    tz = 1'b1; cycles(3);
    chk("done_state", bus.state, S_DONE);
    chk("done_run_en", bus.run_en, 0);
    chk("alarm_entry", bus.alarm, 1);
    ticks(24);
    chk("alarm_hi_24", bus.alarm, 1);
    ticks(1);
    chk("alarm_lo_25", bus.alarm, 0);
    ticks(274);
    chk("done_299", bus.state, S_DONE);
    ticks(1);
    chk("auto_idle", bus.state, S_IDLE);
    chk("auto_idle_alarm", bus.alarm, 0);
    tz = 1'b0;
    press_start();
    tz = 1'b1; cycles(3);
    chk("done_again", bus.state, S_DONE);
    b_stop = 1'b1; cycles(2);
    chk("ack_idle", bus.state, S_IDLE);
    b_stop = 1'b0; tz = 1'b0; cycles(2);

    // clear mid-RUN
    sw_cd = 1'b0;
    press_start();
    ticks(3);
    cnt_clr = 0;
    b_clr = 1'b1; cycles(2);
    chk("clr_run_idle", bus.state, S_IDLE);
    chk("clr_run_en", bus.run_en, 0);
    cycles(4); b_clr = 1'b0; cycles(2);
    chk("clr_pulse_once", cnt_clr, 1);

    // asynchronous reset in DONE, start held through reset
    sw_cd = 1'b1;
    press_start();
    tz = 1'b1; cycles(3); ticks(3);
    chk("done_before_rst", bus.state, S_DONE);
    #2;
    rst_n = 1'b0;
    b_start = 1'b1; sw_cd = 1'b0; tz = 1'b0;
    #1;
    chk("async_rst", act_vec(), 8'h00);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    cycles(2);
    chk("held_start_after_rst", bus.state, S_RUN);
    b_start = 1'b0; cycles(2);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)  b_start = ~b_start;
      if ($urandom_range(0, 15) == 0)  b_stop  = ~b_stop;
      if ($urandom_range(0, 79) == 0)  b_clr   = ~b_clr;
      if ($urandom_range(0, 299) == 0) b_min   = ~b_min;
      if ($urandom_range(0, 299) == 0) b_hour  = ~b_hour;
      if ($urandom_range(0, 49) == 0)  sw_cd   = ~sw_cd;
      if ($urandom_range(0, 19) == 0)  tz      = ~tz;
      tick = ($urandom_range(0, 2) == 0);
      cycle();
    end
    tick = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
